// File: rtl/noc_ni_packetizer.sv
// NoC network-interface injection stage: wraps a request plus payload stream into
// header / data / tail flits behind a single back-pressured output register.
module noc_ni_packetizer #(
   parameter logic [3:0]  X_ID   = 4'd0,
   parameter logic [3:0]  Y_ID   = 4'd0,
   parameter int unsigned FLIT_W = 64,
   parameter logic [3:0]  HEAD_H = 4'hA,
   parameter logic [3:0]  HEAD_E = 4'h5,
   parameter logic [3:0]  TAIL_H = 4'hC,
   parameter logic [3:0]  TAIL_E = 4'h3
) (
   input  logic              i_noc_clk,
   input  logic              i_noc_rst,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic [3:0]        i_req_dst_x,
   input  logic [3:0]        i_req_dst_y,
   input  logic [1:0]        i_req_type,
   input  logic [7:0]        i_req_len,
   input  logic              i_pl_valid,
   output logic              o_pl_ready,
   input  logic [FLIT_W-1:0] i_pl_data,
   output logic              o_sender_valid,
   input  logic              i_sender_ready,
   output logic [FLIT_W-1:0] o_sender_flit,
   output logic              o_sender_is_header,
   output logic              o_sender_is_tail,
   output logic              o_busy,
   output logic [15:0]       o_pkt_sent
);

   typedef enum logic [1:0] {StIdle, StData, StTail} state_e;

   state_e              r_state;
   logic [3:0]          r_seq;
   logic [3:0]          r_pkt_seq;
   logic [3:0]          r_dst_x;
   logic [3:0]          r_dst_y;
   logic [1:0]          r_type;
   logic [7:0]          r_len;
   logic [7:0]          r_beat;
   logic                r_valid;
   logic [FLIT_W-1:0]   r_flit;
   logic                r_is_hdr;
   logic                r_is_tail;
   logic [15:0]         r_pkt_sent;
   logic                w_slot_free;

   function automatic logic [FLIT_W-1:0] make_ctl(
      input logic [3:0] mark_h, input logic [3:0] mark_e, input logic [3:0] dx,
      input logic [3:0] dy, input logic [1:0] ty, input logic [3:0] sq, input logic [7:0] ln);
      logic [FLIT_W-1:0] f;
      f        = '0;
      f[63:26] = {mark_h, X_ID, Y_ID, dx, dy, ty, sq, ln, mark_e};
      return f;
   endfunction

   assign w_slot_free        = !r_valid || i_sender_ready;
   assign o_req_ready        = !i_noc_rst && (r_state == StIdle) && w_slot_free;
   assign o_pl_ready         = !i_noc_rst && (r_state == StData) && w_slot_free;
   assign o_sender_valid     = r_valid;
   assign o_sender_flit      = r_flit;
   assign o_sender_is_header = r_is_hdr;
   assign o_sender_is_tail   = r_is_tail;
   assign o_busy             = (r_state != StIdle) || r_valid;
   assign o_pkt_sent         = r_pkt_sent;

   always_ff @(posedge i_noc_clk) begin
      if (i_noc_rst) begin
         r_state    <= StIdle;
         r_seq      <= 4'd0;
         r_pkt_seq  <= 4'd0;
         r_dst_x    <= 4'd0;
         r_dst_y    <= 4'd0;
         r_type     <= 2'd0;
         r_len      <= 8'd0;
         r_beat     <= 8'd0;
         r_valid    <= 1'b0;
         r_flit     <= '0;
         r_is_hdr   <= 1'b0;
         r_is_tail  <= 1'b0;
         r_pkt_sent <= 16'd0;
      end else begin
         if (r_valid && i_sender_ready && r_is_tail && (r_pkt_sent != 16'hFFFF)) begin
            r_pkt_sent <= r_pkt_sent + 16'd1;
         end
         // Output register only advances when the router has taken (or never had) a flit.
         if (w_slot_free) begin
            r_valid <= 1'b0;
            unique case (r_state)
               StIdle: begin
                  if (i_req_valid) begin
                     r_valid   <= 1'b1;
                     r_flit    <= make_ctl(HEAD_H, HEAD_E, i_req_dst_x, i_req_dst_y,
                                           i_req_type, r_seq, i_req_len);
                     r_is_hdr  <= 1'b1;
                     r_is_tail <= 1'b0;
                     r_dst_x   <= i_req_dst_x;
                     r_dst_y   <= i_req_dst_y;
                     r_type    <= i_req_type;
                     r_len     <= i_req_len;
                     r_pkt_seq <= r_seq;
                     r_seq     <= r_seq + 4'd1;
                     r_beat    <= 8'd0;
                     r_state   <= (i_req_len != 8'd0) ? StData : StTail;
                  end
               end
               StData: begin
                  if (i_pl_valid) begin
                     r_valid   <= 1'b1;
                     r_flit    <= i_pl_data;
                     r_is_hdr  <= 1'b0;
                     r_is_tail <= 1'b0;
                     r_beat    <= r_beat + 8'd1;
                     if ((r_beat + 8'd1) == r_len) begin
                        r_state <= StTail;
                     end
                  end
               end
               StTail: begin
                  r_valid   <= 1'b1;
                  r_flit    <= make_ctl(TAIL_H, TAIL_E, r_dst_x, r_dst_y, r_type, r_pkt_seq,
                                        r_len);
                  r_is_hdr  <= 1'b0;
                  r_is_tail <= 1'b1;
                  r_state   <= StIdle;
               end
               default: r_state <= StIdle;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_noc_ni_packetizer.sv
// Randomised scoreboard bench for noc_ni_packetizer: expected flits are queued at
// request accept and popped by an independent monitor on every router handshake.
module tb_noc_ni_packetizer;

   localparam int XID = 1;
   localparam int YID = 2;

   typedef struct packed {
      logic [63:0] flit;
      logic        hdr;
      logic        tail;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [3:0]  req_dst_x = '0;
   logic [3:0]  req_dst_y = '0;
   logic [1:0]  req_type = '0;
   logic [7:0]  req_len = '0;
   logic        pl_valid;
   logic        pl_ready;
   logic [63:0] pl_data;
   logic        s_valid;
   logic        s_ready;
   logic [63:0] s_flit;
   logic        s_hdr;
   logic        s_tail;
   logic        busy;
   logic [15:0] pkt_sent;

   int          n_checks = 0;
   int          n_fail = 0;
   logic [63:0] pl_q[$];
   exp_t        exp_q[$];
   int          model_seq = 0;
   int          model_sent = 0;
   int          sink_mode = 0;
   bit          pl_bubble = 0;
   bit          strict = 0;
   bit          in_pkt = 0;
   int          pl_ready_pulses = 0;
   int          data_hs = 0;
   logic [63:0] last_hdr = '0;
   bit          prev_stall = 0;
   logic [63:0] held_flit = '0;
   logic [1:0]  held_flags = '0;

   always #5 clk = ~clk;

   noc_ni_packetizer #(
      .X_ID   (4'(XID)),
      .Y_ID   (4'(YID)),
      .FLIT_W (64),
      .HEAD_H (4'hA),
      .HEAD_E (4'h5),
      .TAIL_H (4'hC),
      .TAIL_E (4'h3)
   ) dut (
      .i_noc_clk          (clk),
      .i_noc_rst          (rst),
      .i_req_valid        (req_valid),
      .o_req_ready        (req_ready),
      .i_req_dst_x        (req_dst_x),
      .i_req_dst_y        (req_dst_y),
      .i_req_type         (req_type),
      .i_req_len          (req_len),
      .i_pl_valid         (pl_valid),
      .o_pl_ready         (pl_ready),
      .i_pl_data          (pl_data),
      .o_sender_valid     (s_valid),
      .i_sender_ready     (s_ready),
      .o_sender_flit      (s_flit),
      .o_sender_is_header (s_hdr),
      .o_sender_is_tail   (s_tail),
      .o_busy             (busy),
      .o_pkt_sent         (pkt_sent)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference header/tail word assembled from field values by weighted sums.
   function automatic logic [63:0] ref_ctl(input bit is_tail, input int dx, input int dy,
                                           input int ty, input int sq, input int ln);
      logic [63:0] v;
      v = 64'(is_tail ? 12 : 10) << 60;
      v += 64'(XID) << 56;
      v += 64'(YID) << 52;
      v += 64'(dx) << 48;
      v += 64'(dy) << 44;
      v += 64'(ty) << 42;
      v += 64'(sq % 16) << 38;
      v += 64'(ln) << 30;
      v += 64'(is_tail ? 3 : 5) << 26;
      return v;
   endfunction

   // Router sink: 0 = always ready, 1 = random, 2 = stall each flit for 5 cycles.
   initial begin
      int hold;
      hold    = 0;
      s_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (sink_mode)
            0: s_ready = 1'b1;
            1: s_ready = 1'($urandom_range(1, 0));
            default: begin
               if (s_valid && hold < 5) begin
                  s_ready = 1'b0;
                  hold++;
               end else begin
                  s_ready = 1'b1;
                  hold = 0;
               end
            end
         endcase
      end
   end

   // Payload source: presents the head of pl_q, pops only on an observed handshake.
   initial begin
      bit hs;
      pl_valid = 1'b0;
      pl_data  = '0;
      forever begin
         @(negedge clk);
         hs = pl_valid && pl_ready;
         @(posedge clk);
         #1;
         if (hs && pl_q.size() > 0) void'(pl_q.pop_front());
         if (pl_q.size() > 0 && (!pl_bubble || $urandom_range(1, 0) == 1)) begin
            pl_valid = 1'b1;
            pl_data  = pl_q[0];
         end else begin
            pl_valid = 1'b0;
            pl_data  = {$urandom, $urandom};
         end
      end
   end

   // Monitor: sampled mid-cycle, away from the active edge.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (prev_stall) begin
            chk("hold_flit", s_flit, held_flit);
            chk("hold_flags", 64'({s_hdr, s_tail}), 64'(held_flags));
            chk("hold_valid", 64'(s_valid), 64'd1);
         end
         if (s_valid && !s_ready) begin
            chk("stall_pl_ready", 64'(pl_ready), 64'd0);
            chk("stall_req_ready", 64'(req_ready), 64'd0);
         end
         if (strict && in_pkt) chk("no_gap", 64'(s_valid), 64'd1);
         if (pl_ready) pl_ready_pulses++;
         if (s_valid && s_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_flit: got %h expected none", s_flit);
            end else begin
               e = exp_q.pop_front();
               chk("flit", s_flit, e.flit);
               chk("flags", 64'({s_hdr, s_tail}), 64'({e.hdr, e.tail}));
               if (s_hdr) begin
                  last_hdr = s_flit;
                  in_pkt   = 1'b1;
               end
               if (s_tail) begin
                  in_pkt = 1'b0;
                  model_sent++;
               end
               if (!s_hdr && !s_tail) data_hs++;
            end
         end
         prev_stall = s_valid && !s_ready;
         held_flit  = s_flit;
         held_flags = {s_hdr, s_tail};
      end else begin
         prev_stall = 1'b0;
         in_pkt     = 1'b0;
      end
   end

   task automatic send_pkt(input int dx, input int dy, input int ty, input int ln,
                           input bit fixed, input logic [63:0] w0, input logic [63:0] w1);
      logic [63:0] words[$];
      bit          acc;
      for (int i = 0; i < ln; i++) begin
         if (fixed) words.push_back(i == 0 ? w0 : w1);
         else       words.push_back({$urandom, $urandom});
      end
      foreach (words[i]) pl_q.push_back(words[i]);
      req_dst_x = 4'(dx);
      req_dst_y = 4'(dy);
      req_type  = 2'(ty);
      req_len   = 8'(ln);
      req_valid = 1'b1;
      acc       = 1'b0;
      for (int c = 0; c < 2000 && !acc; c++) begin
         @(negedge clk);
         if (req_ready) acc = 1'b1;
         @(posedge clk);
         #1;
      end
      req_valid = 1'b0;
      if (!acc) begin
         n_checks++;
         n_fail++;
         $display("FAIL req_accept_timeout: got no req_ready expected accept");
      end else begin
         exp_q.push_back('{ref_ctl(1'b0, dx, dy, ty, model_seq, ln), 1'b1, 1'b0});
         foreach (words[i]) exp_q.push_back('{words[i], 1'b0, 1'b0});
         exp_q.push_back('{ref_ctl(1'b1, dx, dy, ty, model_seq, ln), 1'b0, 1'b1});
         model_seq = (model_seq + 1) % 16;
      end
   endtask

   task automatic drain();
      for (int c = 0; c < 5000 && exp_q.size() > 0; c++) begin
         @(posedge clk);
         #1;
      end
      if (exp_q.size() > 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain_timeout: got %0d pending flits expected 0", exp_q.size());
      end
      @(posedge clk);
      #1;
      chk("pkt_sent", 64'(pkt_sent), 64'(model_sent));
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      pl_q.delete();
      exp_q.delete();
      model_seq  = 0;
      model_sent = 0;
      rst = 1'b0;
   endtask

   initial begin
      int p0;
      int d0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      chk("rst_valid", 64'(s_valid), 64'd0);
      chk("rst_flit", s_flit, 64'd0);
      chk("rst_hdr", 64'(s_hdr), 64'd0);
      chk("rst_tail", 64'(s_tail), 64'd0);
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_pl_ready", 64'(pl_ready), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_pkt_sent", 64'(pkt_sent), 64'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Directed len-2 packet at full throughput.
      sink_mode = 0; pl_bubble = 0; strict = 1;
      send_pkt(3, 0, 0, 2, 1'b1, 64'h11, 64'h22);
      drain();
      chk("t1_header", last_hdr, 64'hA123000094000000);
      chk("t1_pkt_sent", 64'(pkt_sent), 64'd1);

      // Zero-length packet.
      p0 = pl_ready_pulses;
      send_pkt(5, 6, 2, 0, 1'b0, '0, '0);
      drain();
      chk("len0_pl_ready_pulses", 64'(pl_ready_pulses - p0), 64'd0);
      chk("len0_len_field", 64'(last_hdr[37:30]), 64'd0);
      strict = 0;

      // Router back-pressure, 5 stalled cycles per flit.
      sink_mode = 2;
      send_pkt(1, 7, 1, 3, 1'b0, '0, '0);
      send_pkt(2, 2, 3, 0, 1'b0, '0, '0);
      drain();

      // Payload bubbles.
      sink_mode = 0; pl_bubble = 1;
      for (int i = 0; i < 3; i++) send_pkt(4, 4, 1, 2, 1'b0, '0, '0);
      drain();

      // Random mix.
      sink_mode = 1;
      for (int i = 0; i < 25; i++) begin
         send_pkt(int'($urandom_range(15, 0)), int'($urandom_range(15, 0)),
                  int'($urandom_range(3, 0)), int'($urandom_range(12, 0)), 1'b0, '0, '0);
      end
      drain();

      // Reset after the first data flit of a len-4 packet.
      sink_mode = 0; pl_bubble = 0;
      d0 = data_hs;
      send_pkt(9, 9, 2, 4, 1'b0, '0, '0);
      for (int c = 0; c < 200 && data_hs == d0; c++) begin
         @(posedge clk);
         #1;
      end
      chk("mid_first_data_seen", 64'(data_hs > d0), 64'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_rst_valid", 64'(s_valid), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      pl_q.delete();
      exp_q.delete();
      model_seq  = 0;
      model_sent = 0;
      rst = 1'b0;
      @(posedge clk);
      #1;
      strict = 1;
      send_pkt(3, 3, 0, 2, 1'b0, '0, '0);
      drain();
      chk("mid_next_seq", 64'(last_hdr[41:38]), 64'd0);

      // Sequence wrap over 17 back-to-back len-1 packets.
      reset_dut();
      for (int i = 0; i < 17; i++) send_pkt(i % 16, 1, 1, 1, 1'b0, '0, '0);
      drain();
      strict = 0;
      chk("wrap_last_seq", 64'(last_hdr[41:38]), 64'd0);
      chk("wrap_pkt_sent", 64'(pkt_sent), 64'd17);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
